// File: rtl/wb_usb_hid_host_mc_if.sv
// Wishbone classic slave bus bundle for the multi-port USB HID host register block.
interface wb_usb_hid_host_mc_if;
    logic [3:0]  wbs_adr;
    logic [31:0] wbs_dat_w;
    logic [31:0] wbs_dat_r;
    logic [3:0]  wbs_sel;
    logic        wbs_cyc;
    logic        wbs_stb;
    logic        wbs_we;
    logic        wbs_ack;
    logic        wbs_stall;
    logic        wbs_err;

    modport master (
        output wbs_adr, wbs_dat_w, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
        input  wbs_dat_r, wbs_ack, wbs_stall, wbs_err
    );

    modport slave (
        input  wbs_adr, wbs_dat_w, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
        output wbs_dat_r, wbs_ack, wbs_stall, wbs_err
    );
endinterface

// File: rtl/wb_usb_hid_host_mc.sv
// Multi-port USB HID host front end: per-port report latches arbitrated into a shared
// report FIFO, LED update handshakes, and a Wishbone register interface with interrupts.
module wb_usb_hid_host_mc #(
    parameter int NUM_PORTS  = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst,
    wb_usb_hid_host_mc_if.slave       wb,
    output logic                      irq,
    input  logic [NUM_PORTS-1:0]      usb_report_stb,
    input  logic [2*NUM_PORTS-1:0]    usb_typ,
    input  logic [NUM_PORTS-1:0]      usb_conn_err,
    input  logic [64*NUM_PORTS-1:0]   usb_hid_report,
    output logic [NUM_PORTS-1:0]      update_leds_stb,
    output logic [4*NUM_PORTS-1:0]    leds,
    input  logic [NUM_PORTS-1:0]      ack_update_leds_stb
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = 69;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    // Wishbone handshake
    logic ack_q;
    logic access;
    logic wr_en;
    logic [31:0] rd_data;

    assign access        = wb.wbs_cyc & wb.wbs_stb & ~ack_q;
    assign wr_en         = access & wb.wbs_we;
    assign wb.wbs_ack    = ack_q & wb.wbs_cyc;
    assign wb.wbs_stall  = 1'b0;
    assign wb.wbs_err    = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{wb.wbs_sel, wb.wbs_dat_w[31:10], wb.wbs_dat_w[7:4]};

    // Registers
    logic [2:0]                  ien;
    logic [2:0]                  isr;
    logic [7:0]                  ovf_cnt;
    logic [NUM_PORTS-1:0]        pend_vld;
    logic [NUM_PORTS-1:0][66:0]  pend_data;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [LW-1:0]               level;
    logic [EW-1:0]               mem [FIFO_DEPTH];
    logic [1:0]                  led_sel;
    logic [NUM_PORTS-1:0]        busy;
    logic [NUM_PORTS-1:0][3:0]   led_q;
    logic [NUM_PORTS-1:0]        upd_q;

    // Arbitration and FIFO control
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] lat_ovf;
    logic                 push_req;
    logic [EW-1:0]        push_entry;
    logic                 pop;
    logic                 push;
    logic                 fifo_drop;
    logic                 full;
    logic [EW-1:0]        head;
    logic [3:0]           ovf_events;
    logic [8:0]           ovf_sum;
    logic [NUM_PORTS-1:0] led_go;
    logic [3:0]           led_cur;
    logic                 led_wr;

    always_comb begin
        grant      = '0;
        push_req   = 1'b0;
        push_entry = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (pend_vld[i] && !push_req) begin
                grant[i]   = 1'b1;
                push_req   = 1'b1;
                push_entry = {2'(i), pend_data[i]};
            end
        end
    end

    // A latch being drained this cycle may take a new strobe without loss
    assign lat_ovf   = usb_report_stb & pend_vld & ~grant;
    assign full      = (level == DEPTH_L);
    assign pop       = wr_en && (wb.wbs_adr == 4'd6) && (level != '0);
    assign push      = push_req && (!full || pop);
    assign fifo_drop = push_req && full && !pop;
    assign head      = (level != '0) ? mem[rd_ptr] : '0;

    always_comb begin
        ovf_events = {3'b0, fifo_drop};
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            ovf_events = ovf_events + 4'(lat_ovf[i]);
        end
        ovf_sum = {1'b0, ovf_cnt} + {5'b0, ovf_events};
    end

    assign led_wr = wr_en && (wb.wbs_adr == 4'd7);

    always_comb begin
        led_go  = '0;
        led_cur = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (led_wr && (wb.wbs_dat_w[9:8] == 2'(i)) && !busy[i]) begin
                led_go[i] = 1'b1;
            end
            if (led_sel == 2'(i)) begin
                led_cur = led_q[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (wb.wbs_adr)
            4'd0: rd_data[2:0] = ien;
            4'd1: rd_data[2:0] = isr;
            4'd2: begin
                rd_data[15:8]   = ovf_cnt;
                rd_data[LW-1:0] = level;
            end
            4'd3: begin
                rd_data[5:4] = head[68:67];
                rd_data[2]   = head[66];
                rd_data[1:0] = head[65:64];
            end
            4'd4: rd_data = head[31:0];
            4'd5: rd_data = head[63:32];
            4'd7: begin
                rd_data[16 +: NUM_PORTS] = busy;
                rd_data[9:8]             = led_sel;
                rd_data[3:0]             = led_cur;
            end
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            ack_q        <= 1'b0;
            wb.wbs_dat_r <= '0;
            ien          <= '0;
            isr          <= '0;
            ovf_cnt      <= '0;
            pend_vld     <= '0;
            pend_data    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            led_sel      <= '0;
            busy         <= '0;
            led_q        <= '0;
            upd_q        <= '0;
        end else begin
            ack_q <= access;
            if (access) begin
                wb.wbs_dat_r <= rd_data;
            end
            if (wr_en && (wb.wbs_adr == 4'd0)) begin
                ien <= wb.wbs_dat_w[2:0];
            end
            // Newly raised events win over a simultaneous write-1-to-clear
            isr <= (isr & ~((wr_en && (wb.wbs_adr == 4'd1)) ? wb.wbs_dat_w[2:0] : 3'b0))
                 | {(|lat_ovf) | fifo_drop, |ack_update_leds_stb, push};
            if (wr_en && (wb.wbs_adr == 4'd2)) begin
                ovf_cnt <= '0;
            end else begin
                ovf_cnt <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
            end
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (usb_report_stb[i]) begin
                    pend_vld[i]  <= 1'b1;
                    pend_data[i] <= {usb_conn_err[i], usb_typ[2*i +: 2], usb_hid_report[64*i +: 64]};
                end else if (grant[i]) begin
                    pend_vld[i] <= 1'b0;
                end
                if (led_go[i]) begin
                    led_q[i] <= wb.wbs_dat_w[3:0];
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
            if (led_wr) begin
                led_sel <= wb.wbs_dat_w[9:8];
            end
            busy  <= (busy & ~ack_update_leds_stb) | led_go;
            upd_q <= led_go;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign irq             = |(isr & ien);
    assign leds            = led_q;
    assign update_leds_stb = upd_q;

endmodule

// File: tb/tb_wb_usb_hid_host_mc.sv
// Directed, table-driven bench for wb_usb_hid_host_mc (2 ports, 4-entry FIFO).
module tb_wb_usb_hid_host_mc;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         irq;
    logic [1:0]   usb_stb = '0;
    logic [3:0]   usb_typ = '0;
    logic [1:0]   usb_err = '0;
    logic [127:0] usb_rep = '0;
    logic [1:0]   upd_stb;
    logic [7:0]   leds;
    logic [1:0]   ack_led = '0;

    int checks = 0;
    int passed = 0;
    int upd_cnt [2] = '{0, 0};

    wb_usb_hid_host_mc_if wbi ();

    wb_usb_hid_host_mc #(.NUM_PORTS(2), .FIFO_DEPTH(4)) dut (
        .wb_clk              (clk),
        .wb_rst              (rst),
        .wb                  (wbi),
        .irq                 (irq),
        .usb_report_stb      (usb_stb),
        .usb_typ             (usb_typ),
        .usb_conn_err        (usb_err),
        .usb_hid_report      (usb_rep),
        .update_leds_stb     (upd_stb),
        .leds                (leds),
        .ack_update_leds_stb (ack_led)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (upd_stb[p]) upd_cnt[p] = upd_cnt[p] + 1;
        end
    end

    typedef struct {
        int          ph;
        logic        we;
        logic [3:0]  adr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input int ph, input logic we, input logic [3:0] adr,
                       input logic [31:0] wd, input logic [31:0] exp);
        vec_t v;
        v.ph = ph; v.we = we; v.adr = adr; v.wd = wd; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 with the bus idle for one cycle
    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wd,
                           output logic [31:0] rd, output bit ok);
        ok = 1'b0;
        rd = '0;
        wbi.wbs_cyc = 1'b1; wbi.wbs_stb = 1'b1; wbi.wbs_we = we;
        wbi.wbs_adr = adr;  wbi.wbs_dat_w = wd;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (wbi.wbs_ack) begin
                ok = 1'b1;
                rd = wbi.wbs_dat_r;
                break;
            end
        end
        wbi.wbs_cyc = 1'b0; wbi.wbs_stb = 1'b0; wbi.wbs_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_phase(input int ph);
        logic [31:0] rd;
        bit ok;
        foreach (tbl[i]) begin
            if (tbl[i].ph == ph) begin
                wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].wd, rd, ok);
                if (!ok) begin
                    checks++;
                    $display("FAIL ph%0d_v%0d ack timeout got=0 exp=1", ph, i);
                end else if (!tbl[i].we) begin
                    check($sformatf("ph%0d_v%0d_adr%0d", ph, i, tbl[i].adr), rd, tbl[i].exp);
                end
            end
        end
    endtask

    task automatic usb_pulse(input logic [1:0] m, input logic [63:0] r0, input logic [63:0] r1,
                             input logic [1:0] t0, input logic [1:0] t1, input logic [1:0] e);
        usb_stb = m; usb_rep = {r1, r0}; usb_typ = {t1, t0}; usb_err = e;
        @(posedge clk); #1;
        usb_stb = '0;
    endtask

    logic [31:0] rd_dummy;
    bit          ok_dummy;

    initial begin
        wbi.wbs_cyc = 1'b0; wbi.wbs_stb = 1'b0; wbi.wbs_we = 1'b0;
        wbi.wbs_adr = '0;   wbi.wbs_dat_w = '0; wbi.wbs_sel = 4'hF;

        // Reset state and basic register access
        add(0,0,4'd0,0,0); add(0,0,4'd1,0,0); add(0,0,4'd2,0,0); add(0,0,4'd3,0,0);
        add(0,0,4'd4,0,0); add(0,0,4'd5,0,0); add(0,0,4'd7,0,0); add(0,0,4'd6,0,0);
        add(0,0,4'd9,0,0); add(0,1,4'd0,32'h1,0); add(0,0,4'd0,0,32'h1);
        // Single report on port 0
        add(1,0,4'd2,0,32'h1); add(1,0,4'd4,0,32'h55667788); add(1,0,4'd5,0,32'h11223344);
        add(1,0,4'd3,0,32'h1); add(1,0,4'd1,0,32'h1); add(1,1,4'd1,32'h1,0);
        add(1,0,4'd1,0,32'h0); add(1,1,4'd6,0,0); add(1,0,4'd2,0,0); add(1,0,4'd4,0,0);
        add(1,0,4'd5,0,0);
        // Two ports strobing together
        add(2,0,4'd2,0,32'h2); add(2,0,4'd3,0,32'h3); add(2,0,4'd4,0,32'hAAAA0001);
        add(2,1,4'd6,0,0); add(2,0,4'd3,0,32'h16); add(2,0,4'd4,0,32'hBBBB0002);
        add(2,0,4'd5,0,32'hBBBB0000); add(2,1,4'd6,0,0); add(2,0,4'd2,0,0);
        add(2,1,4'd1,32'h7,0); add(2,0,4'd1,0,0);
        // Overflow and ordered drain
        add(3,0,4'd2,0,32'h204); add(3,0,4'd1,0,32'h5);
        add(3,0,4'd4,0,32'h100); add(3,1,4'd6,0,0); add(3,0,4'd4,0,32'h101); add(3,1,4'd6,0,0);
        add(3,0,4'd4,0,32'h102); add(3,1,4'd6,0,0); add(3,0,4'd4,0,32'h103); add(3,0,4'd5,0,32'h3);
        add(3,1,4'd6,0,0); add(3,0,4'd2,0,32'h200); add(3,1,4'd2,0,0); add(3,0,4'd2,0,0);
        add(3,1,4'd6,0,0); add(3,0,4'd2,0,0); add(3,1,4'd1,32'h7,0); add(3,0,4'd1,0,0);
        // Full FIFO with simultaneous push and pop
        add(4,0,4'd2,0,32'h4); add(4,0,4'd4,0,32'h201); add(4,1,4'd6,0,0);
        add(4,0,4'd4,0,32'h202); add(4,1,4'd6,0,0); add(4,0,4'd4,0,32'h203); add(4,1,4'd6,0,0);
        add(4,0,4'd4,0,32'h2FF); add(4,1,4'd6,0,0); add(4,0,4'd2,0,0); add(4,0,4'd1,0,32'h1);
        add(4,1,4'd1,32'h7,0);
        // LED handshake
        add(5,1,4'd7,32'h105,0); add(5,0,4'd7,0,32'h20105);
        add(6,1,4'd7,32'h10A,0); add(6,0,4'd7,0,32'h20105);
        add(6,1,4'd7,32'h30F,0); add(6,0,4'd7,0,32'h20300);
        add(7,0,4'd1,0,32'h2); add(7,1,4'd7,32'h109,0); add(7,0,4'd7,0,32'h20109);
        add(7,1,4'd1,32'h7,0);
        // Setup for reset mid-activity
        add(8,1,4'd7,32'h003,0); add(8,1,4'd0,32'h7,0);
        add(9,0,4'd2,0,32'h3);
        // After reset
        add(10,0,4'd2,0,0); add(10,0,4'd7,0,0); add(10,0,4'd0,0,0); add(10,0,4'd1,0,0);
        add(10,0,4'd3,0,0); add(10,0,4'd4,0,0);

        idle(2);
        check("rst_irq", {31'b0, irq}, 0);
        check("rst_ack", {31'b0, wbi.wbs_ack}, 0);
        check("rst_leds", {24'b0, leds}, 0);
        rst = 1'b0;
        idle(1);
        check("stall_err", {30'b0, wbi.wbs_stall, wbi.wbs_err}, 0);
        run_phase(0);

        usb_pulse(2'b01, 64'h1122334455667788, 64'h0, 2'd1, 2'd0, 2'b00);
        check("lat_irq_early", {31'b0, irq}, 0);
        idle(1);
        check("lat_irq_push", {31'b0, irq}, 1);
        run_phase(1);
        check("irq_cleared", {31'b0, irq}, 0);

        usb_pulse(2'b11, 64'h0000_0000_AAAA_0001, 64'hBBBB_0000_BBBB_0002, 2'd3, 2'd2, 2'b10);
        idle(2);
        run_phase(2);

        for (int i = 0; i < 6; i++) begin
            usb_pulse(2'b01, {32'(i), 32'h100 + 32'(i)}, 64'h0, 2'd0, 2'd0, 2'b00);
            idle(2);
        end
        run_phase(3);

        for (int i = 0; i < 4; i++) begin
            usb_pulse(2'b01, {32'(i), 32'h200 + 32'(i)}, 64'h0, 2'd0, 2'd0, 2'b00);
            idle(2);
        end
        // Capture now, then start a POP whose access edge coincides with the push
        usb_pulse(2'b01, {32'h0, 32'h2FF}, 64'h0, 2'd0, 2'd0, 2'b00);
        wb_xfer(1'b1, 4'd6, 32'h0, rd_dummy, ok_dummy);
        if (!ok_dummy) begin
            checks++;
            $display("FAIL pushpop ack timeout got=0 exp=1");
        end
        run_phase(4);

        run_phase(5);
        check("led_out_a", {24'b0, leds}, 32'h50);
        check("led_pulse_a", upd_cnt[1], 1);
        run_phase(6);
        check("led_out_b", {24'b0, leds}, 32'h50);
        check("led_pulse_b", upd_cnt[1], 1);
        ack_led = 2'b10;
        idle(1);
        ack_led = 2'b00;
        run_phase(7);
        check("led_out_c", {24'b0, leds}, 32'h90);
        check("led_pulse_c", upd_cnt[1], 2);
        check("led_pulse_p0", upd_cnt[0], 0);

        run_phase(8);
        for (int i = 0; i < 3; i++) begin
            usb_pulse(2'b10, 64'h0, 64'h7777 + 64'(i), 2'd0, 2'd1, 2'b00);
            idle(1);
        end
        run_phase(9);
        check("pre_rst_irq", {31'b0, irq}, 1);
        check("pre_rst_leds", {24'b0, leds}, 32'h93);
        check("pre_rst_pulse0", upd_cnt[0], 1);

        wbi.wbs_cyc = 1'b1; wbi.wbs_stb = 1'b1; wbi.wbs_we = 1'b0; wbi.wbs_adr = 4'd2;
        usb_stb = 2'b10; usb_rep = {64'hDEAD, 64'h0};
        @(posedge clk); #1;
        usb_stb = 2'b00;
        check("mid_ack", {31'b0, wbi.wbs_ack}, 1);
        rst = 1'b1;
        #1;
        check("async_ack", {31'b0, wbi.wbs_ack}, 0);
        check("async_irq", {31'b0, irq}, 0);
        check("async_leds", {24'b0, leds}, 0);
        check("async_upd", {30'b0, upd_stb}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wbi.wbs_cyc = 1'b0; wbi.wbs_stb = 1'b0;
        idle(3);
        run_phase(10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
